// File: rtl/mure_pkg.sv
// rtl/mure_pkg.sv - shared widths, retire bundle record, serializer state encoding
package mure_pkg;

    localparam int XLEN      = 32;
    localparam int INST_LEN  = 32;
    localparam int CAUSE_LEN = 5;
    localparam int NRET      = 2;
    localparam int IDXW      = (NRET > 1) ? $clog2(NRET) : 1;

    typedef struct packed {
        logic [NRET-1:0]                valids;
        logic [NRET-1:0][INST_LEN-1:0]  inst;
        logic [NRET-1:0][XLEN-1:0]      pc;
        logic                           exception;
        logic                           interrupt;
        logic [CAUSE_LEN-1:0]           cause;
        logic [XLEN-1:0]                tval;
        logic [XLEN-1:0]                epc;
    } retire_bundle_t;

    typedef enum logic [1:0] {
        IDLE,
        INSTR,
        TRAP
    } ser_state_e;

    // Returns {found, slot}: the lowest valid slot at or above 'from'.
    function automatic logic [IDXW:0] find_slot(input logic [NRET-1:0] v, input int from);
        logic [IDXW:0] r;
        r = '0;
        for (int i = NRET - 1; i >= 0; i--) begin
            if (v[i] && (i >= from)) begin
                r = {1'b1, IDXW'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/retire_serializer_if.sv
// rtl/retire_serializer_if.sv - commit-side bundle port and encoder-side record stream
interface retire_serializer_if;
    import mure_pkg::*;

    logic [NRET-1:0]          valids_i;
    logic [NRET*INST_LEN-1:0] inst_i;
    logic [NRET*XLEN-1:0]     pc_i;
    logic                     exception_i;
    logic                     interrupt_i;
    logic [CAUSE_LEN-1:0]     cause_i;
    logic [XLEN-1:0]          tval_i;
    logic [XLEN-1:0]          epc_i;
    logic                     ready_o;

    logic                     valid_o;
    logic                     ready_i;
    logic                     iretired_o;
    logic                     exception_o;
    logic                     interrupt_o;
    logic [INST_LEN-1:0]      inst_data_o;
    logic [XLEN-1:0]          pc_o;
    logic [CAUSE_LEN-1:0]     cause_o;
    logic [XLEN-1:0]          tval_o;
    logic [XLEN-1:0]          epc_o;

    modport master (
        output valids_i, inst_i, pc_i, exception_i, interrupt_i, cause_i, tval_i, epc_i,
        output ready_i,
        input  ready_o, valid_o, iretired_o, exception_o, interrupt_o,
        input  inst_data_o, pc_o, cause_o, tval_o, epc_o
    );

    modport slave (
        input  valids_i, inst_i, pc_i, exception_i, interrupt_i, cause_i, tval_i, epc_i,
        input  ready_i,
        output ready_o, valid_o, iretired_o, exception_o, interrupt_o,
        output inst_data_o, pc_o, cause_o, tval_o, epc_o
    );

endinterface

// File: rtl/mure_bundle_fifo.sv
// rtl/mure_bundle_fifo.sv - DEPTH-entry FIFO with combinational head and second-entry peek
module mure_bundle_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         head_next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW:0]      rptr_inc;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign rptr_inc = rptr + (AW+1)'(1);

    // Extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;

    assign head      = mem[rptr[AW-1:0]];
    assign head_next = mem[rptr_inc[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/retire_serializer.sv
// rtl/retire_serializer.sv - multi-retire bundles to one trace record per cycle; MURE_STALL_CNT_EN adds stall_cnt_o
module retire_serializer
    import mure_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    retire_serializer_if.slave   bus
`ifdef MURE_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    retire_bundle_t in_b;
    retire_bundle_t head;
    retire_bundle_t head_nx;
    retire_bundle_t nb;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;
    logic           present;
    logic           push;
    logic           pop;
    logic           fire;
    logic           nb_ok;
    logic [IDXW:0]  more_slot;
    logic [IDXW:0]  start_slot;
    ser_state_e     state;
    ser_state_e     adv_state;
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] adv_idx;

    always_comb begin
        in_b           = '0;
        in_b.valids    = bus.valids_i;
        in_b.inst      = bus.inst_i;
        in_b.pc        = bus.pc_i;
        in_b.exception = bus.exception_i;
        in_b.interrupt = bus.interrupt_i;
        in_b.cause     = bus.cause_i;
        in_b.tval      = bus.tval_i;
        in_b.epc       = bus.epc_i;
    end

    assign present     = (|bus.valids_i) || bus.exception_i;
    assign push        = present && !full;
    assign bus.ready_o = !full;
    assign fire        = bus.valid_o && bus.ready_i;

    mure_bundle_fifo #(
        .WIDTH ($bits(retire_bundle_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (push),
        .wdata     (in_b),
        .pop       (pop),
        .head      (head),
        .head_next (head_nx),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign more_slot = find_slot(head.valids, int'(idx) + 1);
    assign pop = fire && ((state == TRAP) ||
                          ((state == INSTR) && !more_slot[IDXW] && !head.exception));

    // Bundle that becomes head after a pop: the queued second entry, else one
    // being pushed this very cycle, so a fresh head is presented with no bubble.
    assign nb    = (count > CW'(1)) ? head_nx : in_b;
    assign nb_ok = (count > CW'(1)) || push;
    assign start_slot = find_slot(nb.valids, 0);

    always_comb begin
        adv_state = IDLE;
        adv_idx   = '0;
        if (nb_ok) begin
            adv_state = start_slot[IDXW] ? INSTR : TRAP;
            adv_idx   = start_slot[IDXW] ? start_slot[IDXW-1:0] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        state <= adv_state;
                        idx   <= adv_idx;
                    end
                end
                INSTR: begin
                    if (fire) begin
                        if (more_slot[IDXW]) begin
                            idx <= more_slot[IDXW-1:0];
                        end else if (head.exception) begin
                            state <= TRAP;
                            idx   <= '0;
                        end else begin
                            state <= adv_state;
                            idx   <= adv_idx;
                        end
                    end
                end
                TRAP: begin
                    if (fire) begin
                        state <= adv_state;
                        idx   <= adv_idx;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    assign bus.valid_o     = (state != IDLE);
    assign bus.iretired_o  = (state == INSTR);
    assign bus.exception_o = (state == TRAP);
    assign bus.interrupt_o = (state == TRAP) && head.interrupt;
    assign bus.inst_data_o = (state == INSTR) ? head.inst[idx] : '0;
    assign bus.pc_o        = (state == INSTR) ? head.pc[idx]   : '0;
    assign bus.cause_o     = (state == TRAP)  ? head.cause     : '0;
    assign bus.tval_o      = (state == TRAP)  ? head.tval      : '0;
    assign bus.epc_o       = (state == TRAP)  ? head.epc       : '0;

`ifdef MURE_STALL_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
        end else if (present && full && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_retire_serializer.sv
// tb/tb_retire_serializer.sv - scoreboard bench for retire_serializer with randomized bundles
module tb_retire_serializer;
    import mure_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    retire_serializer_if bus();

`ifdef MURE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    retire_serializer #(.DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
`ifdef MURE_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    typedef struct {
        logic                 iret;
        logic                 exc;
        logic                 intr;
        logic [INST_LEN-1:0]  inst;
        logic [XLEN-1:0]      pc;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [XLEN-1:0]      epc;
        bit                   last;
    } rec_t;

    rec_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   occ = 0;
    bit   push_ev = 0;
    bit   pop_ev = 0;
    bit   stall_prev = 0;
    bit   rand_ready = 0;
    rec_t got_r, held_r, exp_r;

    function automatic rec_t zero_rec();
        rec_t r;
        r.iret = 0; r.exc = 0; r.intr = 0; r.inst = '0; r.pc = '0;
        r.cause = '0; r.tval = '0; r.epc = '0; r.last = 0;
        return r;
    endfunction

    function automatic rec_t get_out();
        rec_t r;
        r.iret = bus.iretired_o; r.exc = bus.exception_o; r.intr = bus.interrupt_o;
        r.inst = bus.inst_data_o; r.pc = bus.pc_o; r.cause = bus.cause_o;
        r.tval = bus.tval_o; r.epc = bus.epc_o; r.last = 0;
        return r;
    endfunction

    function automatic string rstr(rec_t r);
        return $sformatf("iret=%0b exc=%0b intr=%0b inst=%h pc=%h cause=%0d tval=%h epc=%h",
                         r.iret, r.exc, r.intr, r.inst, r.pc, r.cause, r.tval, r.epc);
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic chk_rec(string name, rec_t g, rec_t e);
        n_chk++;
        if (g.iret !== e.iret || g.exc !== e.exc || g.intr !== e.intr || g.inst !== e.inst ||
            g.pc !== e.pc || g.cause !== e.cause || g.tval !== e.tval || g.epc !== e.epc) begin
            n_fail++;
            $display("FAIL %s: got {%s} expected {%s}", name, rstr(g), rstr(e));
        end
    endtask

    // Reference: each slot valid in order becomes an instruction record, then one trap record.
    task automatic expect_bundle(retire_bundle_t b);
        int n, k;
        rec_t r;
        n = $countones(b.valids) + (b.exception ? 1 : 0);
        k = 0;
        for (int i = 0; i < NRET; i++) begin
            if (b.valids[i]) begin
                r = zero_rec();
                r.iret = 1; r.inst = b.inst[i]; r.pc = b.pc[i];
                k++;
                r.last = (k == n);
                exp_q.push_back(r);
            end
        end
        if (b.exception) begin
            r = zero_rec();
            r.exc = 1; r.intr = b.interrupt; r.cause = b.cause; r.tval = b.tval; r.epc = b.epc;
            r.last = 1;
            exp_q.push_back(r);
        end
    endtask

    function automatic retire_bundle_t mk(logic [NRET-1:0] v, logic [XLEN-1:0] pc0,
                                          logic [XLEN-1:0] pc1, logic exc, logic intr,
                                          logic [CAUSE_LEN-1:0] cause, logic [XLEN-1:0] epc);
        retire_bundle_t b;
        b = '0;
        b.valids = v;
        b.pc[0] = pc0; b.pc[1] = pc1;
        b.inst[0] = 32'h0000_0013 ^ pc0;
        b.inst[1] = 32'h0010_0093 ^ pc1;
        b.exception = exc; b.interrupt = intr; b.cause = cause;
        b.tval = 32'hbad0_0000 | epc; b.epc = epc;
        return b;
    endfunction

    task automatic apply(retire_bundle_t b);
        bus.valids_i = b.valids; bus.inst_i = b.inst; bus.pc_i = b.pc;
        bus.exception_i = b.exception; bus.interrupt_i = b.interrupt;
        bus.cause_i = b.cause; bus.tval_i = b.tval; bus.epc_i = b.epc;
    endtask

    // Called and returns 1 time unit after a rising edge; holds the offer until taken.
    task automatic drive(input retire_bundle_t b, input int max_cyc, output bit acc);
        bit pres;
        pres = (|b.valids) || b.exception;
        acc = 0;
        apply(b);
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (pres && bus.ready_o) begin
                expect_bundle(b);
                push_ev = 1;
                acc = 1;
            end
            @(posedge clk); #1;
            if (acc || !pres) break;
        end
        apply('0);
    endtask

    task automatic check_burst(int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk($sformatf("burst_valid_%0d", k), 64'(bus.valid_o), 64'd1);
        end
        @(negedge clk);
        chk("burst_end", 64'(bus.valid_o), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(int max_cyc);
        for (int c = 0; c < max_cyc; c++) begin
            if (exp_q.size() == 0 && !bus.valid_o) break;
            @(posedge clk); #1;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    always @(posedge clk) begin
        if (!rst_n) occ = 0;
        else occ = occ + int'(push_ev) - int'(pop_ev);
        push_ev = 0;
        pop_ev = 0;
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) bus.ready_i = ($urandom_range(0, 3) != 0);
    end

    // Monitor: checks ready against modelled occupancy, pops and compares on every handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            got_r = get_out();
            chk("ready_o", 64'(bus.ready_o), 64'(occ < DEPTH));
            if (bus.valid_o) begin
                if (stall_prev) chk_rec("hold_stable", got_r, held_r);
                if (bus.ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_record: got {%s} expected none", rstr(got_r));
                    end else begin
                        exp_r = exp_q.pop_front();
                        chk_rec("record", got_r, exp_r);
                        if (exp_r.last) pop_ev = 1;
                    end
                end
            end else begin
                chk_rec("idle_zero", got_r, zero_rec());
            end
            stall_prev = bus.valid_o && !bus.ready_i;
            held_r = got_r;
        end else begin
            stall_prev = 0;
        end
    end

    initial begin
        retire_bundle_t b;
        bit acc;
        apply('0);
        bus.ready_i = 1;
        #2;
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_ready", 64'(bus.ready_o), 64'd1);
        chk_rec("rst_fields", get_out(), zero_rec());
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;

        drive(mk(2'b11, 32'h100, 32'h104, 0, 0, 0, 0), 10, acc);
        check_burst(2);
        drive(mk(2'b10, 32'h300, 32'h308, 0, 0, 0, 0), 10, acc);
        check_burst(1);
        drive(mk(2'b01, 32'h400, 32'h0, 1, 0, 5'd2, 32'h200), 10, acc);
        check_burst(2);
        drive(mk(2'b00, 32'h0, 32'h0, 1, 1, 5'd7, 32'h500), 10, acc);
        check_burst(1);

        bus.ready_i = 0;
        for (int j = 0; j < DEPTH; j++) begin
            drive(mk(2'b11, 32'h1000 + 32'(j * 16), 32'h1004 + 32'(j * 16), 0, 0, 0, 0), 5, acc);
            chk($sformatf("fill_acc_%0d", j), 64'(acc), 64'd1);
        end
        @(negedge clk);
        chk("full_ready", 64'(bus.ready_o), 64'd0);
        @(posedge clk); #1;
        drive(mk(2'b11, 32'h2000, 32'h2004, 0, 0, 0, 0), 3, acc);
        chk("fifth_not_acc", 64'(acc), 64'd0);
        bus.ready_i = 1;
        wait_drain(50);

        rand_ready = 1;
        for (int n = 0; n < 300; n++) begin
            b = '0;
            b.valids = NRET'($urandom_range(0, 3));
            b.inst[0] = $urandom; b.inst[1] = $urandom;
            b.pc[0] = $urandom; b.pc[1] = $urandom;
            b.exception = ($urandom_range(0, 3) == 0);
            b.interrupt = 1'($urandom_range(0, 1));
            b.cause = CAUSE_LEN'($urandom);
            b.tval = $urandom; b.epc = $urandom;
            drive(b, 200, acc);
            if ((|b.valids || b.exception) && !acc) chk("offer_timeout", 64'd0, 64'd1);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_ready = 0;
        bus.ready_i = 1;
        wait_drain(200);

        bus.ready_i = 0;
        drive(mk(2'b11, 32'h700, 32'h704, 1, 0, 5'd3, 32'h710), 5, acc);
        drive(mk(2'b11, 32'h800, 32'h804, 0, 0, 0, 0), 5, acc);
        @(posedge clk); #1;
        rst_n = 0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", 64'(bus.valid_o), 64'd0);
        chk("mid_rst_ready", 64'(bus.ready_o), 64'd1);
        chk_rec("mid_rst_fields", get_out(), zero_rec());
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        bus.ready_i = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_rst_quiet", 64'(bus.valid_o), 64'd0);
        end
        @(posedge clk); #1;
        drive(mk(2'b11, 32'h900, 32'h904, 0, 0, 0, 0), 10, acc);
        check_burst(2);
        wait_drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
